// File: rtl/cla_pkg.sv
// cla_pkg: shared types and widths for the shared-adder scheduler.
package cla_pkg;
    localparam int BYTE_W = 8;
    localparam int ID_W = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [ID_W-1:0] id_t;
endpackage

// File: rtl/cla_adder8.sv
// cla_adder8: combinational 8-bit carry-lookahead adder, every carry expanded from g/p and cin.
module cla_adder8
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);
    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              pp;
    assign g = a & b;
    assign p = a ^ b;
    // c[i+1] is a flat sum of products over g/p/cin, no carry feeds another carry
    always_comb begin
        c = '0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end
    assign sum = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];
endmodule

// File: rtl/cla_add_sched.sv
// cla_add_sched: round-robin sharing of one CLA byte adder between two multi-byte requesters.
// Defining CLA_SUB_EN adds per-transaction subtract (A-B) via req0_sub/req1_sub.
module cla_add_sched
    import cla_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_a,
    input  logic [BYTE_W-1:0] req0_b,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_a,
    input  logic [BYTE_W-1:0] req1_b,
    input  logic              req1_last,
    output logic              req1_ready,
`ifdef CLA_SUB_EN
    input  logic              req0_sub,
    input  logic              req1_sub,
`endif
    input  logic              res_ready,
    output logic              res_valid,
    output logic [BYTE_W-1:0] res_sum,
    output logic              res_cout,
    output logic              res_last,
    output logic              res_id,
    output logic [IDX_W-1:0]  res_idx,
    output logic              busy
);
    state_t            state;
    logic              rr_ptr;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic              out_free;
    logic              own;
    logic              accept;
    logic              first;
    logic              sub_now;
    logic              cin;
    logic              grant;
    logic              sel_last;
    logic              add_cout;
    logic [BYTE_W-1:0] sel_a;
    logic [BYTE_W-1:0] sel_b;
    logic [BYTE_W-1:0] b_eff;
    logic [BYTE_W-1:0] sum;
`ifdef CLA_SUB_EN
    logic              sub;
`endif
    assign out_free = !res_valid || res_ready;
    assign req0_ready = (state == OWN0) && out_free;
    assign req1_ready = (state == OWN1) && out_free;
    assign own = state == OWN1;
    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_a = own ? req1_a : req0_a;
    assign sel_b = own ? req1_b : req0_b;
    assign sel_last = own ? req1_last : req0_last;
    // idx saturates and is cleared only at the end, so zero marks the first beat
    assign first = idx == '0;
`ifdef CLA_SUB_EN
    assign sub_now = first ? (own ? req1_sub : req0_sub) : sub;
`else
    assign sub_now = 1'b0;
`endif
    assign b_eff = sub_now ? ~sel_b : sel_b;
    assign cin = first ? sub_now : carry;
    assign grant = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign busy = state != IDLE;
    cla_adder8 u_add (
        .a    (sel_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (add_cout)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= 1'b0;
            carry <= 1'b0;
            idx <= '0;
            res_valid <= 1'b0;
            res_sum <= '0;
            res_cout <= 1'b0;
            res_last <= 1'b0;
            res_id <= 1'b0;
            res_idx <= '0;
`ifdef CLA_SUB_EN
            sub <= 1'b0;
`endif
        end else begin
            if (state == IDLE && (req0_valid || req1_valid)) begin
                state <= grant ? OWN1 : OWN0;
                rr_ptr <= !grant;
            end
            if (accept) begin
                res_valid <= 1'b1;
                res_sum <= sum;
                res_cout <= add_cout;
                res_last <= sel_last;
                res_id <= own;
                res_idx <= idx;
                carry <= sel_last ? 1'b0 : add_cout;
                idx <= sel_last ? '0 : (idx == '1 ? idx : idx + IDX_W'(1));
`ifdef CLA_SUB_EN
                sub <= sub_now;
`endif
                if (sel_last) state <= IDLE;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cla_add_sched.sv
// tb_cla_add_sched: scoreboard bench for cla_add_sched; exercises subtract when CLA_SUB_EN is defined.
module tb_cla_add_sched;
    localparam int IDX_W = 4;
    typedef logic [14:0] res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic res_ready = 1'b0;
`ifdef CLA_SUB_EN
    logic req0_sub = 1'b0, req1_sub = 1'b0;
`endif
    logic req0_ready, req1_ready, res_valid, res_cout, res_last, res_id, busy;
    logic [7:0] res_sum;
    logic [IDX_W-1:0] res_idx;

    int checks = 0;
    int failures = 0;
    res_t exp_q[$];
    res_t got_q[$];
    res_t mon_got, mon_exp;
    logic m_carry[2], m_first[2], m_sub[2];
    logic [3:0] m_idx[2];
    logic [7:0] ma, mb;
    logic ms, mci, mlast;
    logic [8:0] mr;

    always #5 clk = ~clk;

    cla_add_sched #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
`ifdef CLA_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_last   (res_last),
        .res_id     (res_id),
        .res_idx    (res_idx),
        .busy       (busy)
    );

    function automatic res_t pk(logic [7:0] s, logic c, logic l, logic i, logic [3:0] x);
        return {s, c, l, i, x};
    endfunction

    // Inputs only change at posedge+1, so values seen at negedge are those at the next edge.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            mon_got = {res_sum, res_cout, res_last, res_id, res_idx};
            got_q.push_back(mon_got);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected got=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard got=%h expected=%h (sum,cout,last,id,idx)", mon_got, mon_exp);
                end
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            for (int n = 0; n < 2; n++) begin
                m_carry[n] = 1'b0;
                m_first[n] = 1'b1;
                m_sub[n] = 1'b0;
                m_idx[n] = 4'd0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (n == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                    ma = n == 0 ? req0_a : req1_a;
                    mb = n == 0 ? req0_b : req1_b;
                    mlast = n == 0 ? req0_last : req1_last;
`ifdef CLA_SUB_EN
                    ms = m_first[n] ? (n == 0 ? req0_sub : req1_sub) : m_sub[n];
`else
                    ms = 1'b0;
`endif
                    mci = m_first[n] ? ms : m_carry[n];
                    mr = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + {8'b0, mci};
                    exp_q.push_back({mr[7:0], mr[8], mlast, n[0], m_idx[n]});
                    m_sub[n] = ms;
                    m_first[n] = mlast;
                    m_carry[n] = mlast ? 1'b0 : mr[8];
                    m_idx[n] = mlast ? 4'd0 : (m_idx[n] == 4'hF ? 4'hF : m_idx[n] + 4'd1);
                end
            end
        end
    end

    task automatic beat(input bit id, input logic [7:0] a, input logic [7:0] b, input logic last);
        int n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_last = last;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_last = last;
        end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready)) begin
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout id=%0d got=ready_low expected=ready_high", id);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || res_valid) begin
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout got=pending%0d expected=0", exp_q.size());
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b expected=0", res_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready got=%b expected=00", {req0_ready, req1_ready});
        end
        if ({res_sum, res_cout, res_last, res_id, res_idx} !== 15'd0) begin
            failures++; $display("FAIL reset_res_fields got=%h expected=0", {res_sum, res_cout, res_last, res_id, res_idx});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_two_beat();
        res_ready = 1'b1;
        got_q.delete();
        beat(0, 8'hFF, 8'h01, 1'b0);
        beat(0, 8'h00, 8'h00, 1'b1);
        drain();
        checks += 3;
        if (got_q.size() != 2) begin failures++; $display("FAIL two_beat_count got=%0d expected=2", got_q.size()); end
        if (got_q[0] !== pk(8'h00, 1'b1, 1'b0, 1'b0, 4'd0)) begin failures++; $display("FAIL two_beat_b0 got=%h expected=%h", got_q[0], pk(8'h00, 1'b1, 1'b0, 1'b0, 4'd0)); end
        if (got_q[1] !== pk(8'h01, 1'b0, 1'b1, 1'b0, 4'd1)) begin failures++; $display("FAIL two_beat_b1 got=%h expected=%h", got_q[1], pk(8'h01, 1'b0, 1'b1, 1'b0, 4'd1)); end
    endtask

    task automatic test_round_robin();
        res_t want[4];
        want = '{pk(8'h03, 1'b0, 1'b0, 1'b0, 4'd0), pk(8'h07, 1'b0, 1'b1, 1'b0, 4'd1),
                 pk(8'h30, 1'b0, 1'b0, 1'b1, 4'd0), pk(8'h70, 1'b0, 1'b1, 1'b1, 4'd1)};
        do_reset();
        res_ready = 1'b1;
        got_q.delete();
        fork
            begin beat(0, 8'h01, 8'h02, 1'b0); beat(0, 8'h03, 8'h04, 1'b1); end
            begin beat(1, 8'h10, 8'h20, 1'b0); beat(1, 8'h30, 8'h40, 1'b1); end
        join
        drain();
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL rr_count got=%0d expected=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin failures++; $display("FAIL rr_beat%0d got=%h expected=%h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_stall();
        res_ready = 1'b0;
        got_q.delete();
        fork
            begin
                beat(0, 8'h10, 8'h20, 1'b0);
                beat(0, 8'hF0, 8'h10, 1'b0);
                beat(0, 8'h00, 8'h00, 1'b1);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!res_valid && n < 50) begin n++; @(negedge clk); end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    checks += 2;
                    if ({res_valid, res_sum, res_cout, res_last, res_id, res_idx} !== {1'b1, pk(8'h30, 1'b0, 1'b0, 1'b0, 4'd0)}) begin
                        failures++;
                        $display("FAIL stall_hold%0d got=%b_%h expected=1_%h", k, res_valid, {res_sum, res_cout, res_last, res_id, res_idx}, pk(8'h30, 1'b0, 1'b0, 1'b0, 4'd0));
                    end
                    if (req0_ready !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%b expected=0", k, req0_ready); end
                end
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        drain();
        checks += 4;
        if (got_q.size() != 3) begin failures++; $display("FAIL stall_count got=%0d expected=3", got_q.size()); end
        if (got_q[0] !== pk(8'h30, 1'b0, 1'b0, 1'b0, 4'd0)) begin failures++; $display("FAIL stall_b0 got=%h expected=%h", got_q[0], pk(8'h30, 1'b0, 1'b0, 1'b0, 4'd0)); end
        if (got_q[1] !== pk(8'h00, 1'b1, 1'b0, 1'b0, 4'd1)) begin failures++; $display("FAIL stall_b1 got=%h expected=%h", got_q[1], pk(8'h00, 1'b1, 1'b0, 1'b0, 4'd1)); end
        if (got_q[2] !== pk(8'h01, 1'b0, 1'b1, 1'b0, 4'd2)) begin failures++; $display("FAIL stall_b2 got=%h expected=%h", got_q[2], pk(8'h01, 1'b0, 1'b1, 1'b0, 4'd2)); end
    endtask

    task automatic test_single_beat();
        res_ready = 1'b1;
        got_q.delete();
        beat(0, 8'h80, 8'h80, 1'b1);
        beat(1, 8'h01, 8'h01, 1'b1);
        drain();
        checks += 2;
        if (got_q[0] !== pk(8'h00, 1'b1, 1'b1, 1'b0, 4'd0)) begin failures++; $display("FAIL single_a got=%h expected=%h", got_q[0], pk(8'h00, 1'b1, 1'b1, 1'b0, 4'd0)); end
        if (got_q[1] !== pk(8'h02, 1'b0, 1'b1, 1'b1, 4'd0)) begin failures++; $display("FAIL single_b got=%h expected=%h", got_q[1], pk(8'h02, 1'b0, 1'b1, 1'b1, 4'd0)); end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        got_q.delete();
        beat(0, 8'hFF, 8'hFF, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b expected=0", res_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b expected=0", busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(0, 8'h01, 8'h01, 1'b1);
        drain();
        checks += 3;
        if (got_q.size() != 2) begin failures++; $display("FAIL rstmid_count got=%0d expected=2", got_q.size()); end
        if (got_q[0] !== pk(8'hFE, 1'b1, 1'b0, 1'b0, 4'd0)) begin failures++; $display("FAIL rstmid_b0 got=%h expected=%h", got_q[0], pk(8'hFE, 1'b1, 1'b0, 1'b0, 4'd0)); end
        if (got_q[1] !== pk(8'h02, 1'b0, 1'b1, 1'b0, 4'd0)) begin failures++; $display("FAIL rstmid_new got=%h expected=%h", got_q[1], pk(8'h02, 1'b0, 1'b1, 1'b0, 4'd0)); end
    endtask

    task automatic test_back_to_back();
        time t0, t1;
        res_ready = 1'b1;
        got_q.delete();
        t0 = $time;
        for (int i = 0; i < 18; i++) beat(1, 8'($urandom), 8'($urandom), i == 17);
        t1 = $time;
        drain();
        checks += 4;
        if ((t1 - t0) / 10 != 19) begin failures++; $display("FAIL b2b_cycles got=%0d expected=19", (t1 - t0) / 10); end
        if (got_q.size() != 18) begin failures++; $display("FAIL b2b_count got=%0d expected=18", got_q.size()); end
        if (got_q[14][3:0] !== 4'd14) begin failures++; $display("FAIL b2b_idx14 got=%0d expected=14", got_q[14][3:0]); end
        if (got_q[17][3:0] !== 4'd15) begin failures++; $display("FAIL b2b_idx_sat got=%0d expected=15", got_q[17][3:0]); end
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub();
        res_ready = 1'b1;
        got_q.delete();
        req0_sub = 1'b1;
        beat(0, 8'h00, 8'h01, 1'b0);
        req0_sub = 1'b0;
        beat(0, 8'h00, 8'h00, 1'b1);
        drain();
        checks += 2;
        if (got_q[0] !== pk(8'hFF, 1'b0, 1'b0, 1'b0, 4'd0)) begin failures++; $display("FAIL sub_b0 got=%h expected=%h", got_q[0], pk(8'hFF, 1'b0, 1'b0, 1'b0, 4'd0)); end
        if (got_q[1] !== pk(8'hFF, 1'b0, 1'b1, 1'b0, 4'd1)) begin failures++; $display("FAIL sub_b1 got=%h expected=%h", got_q[1], pk(8'hFF, 1'b0, 1'b1, 1'b0, 4'd1)); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_two_beat();
        test_round_robin();
        test_stall();
        test_single_beat();
        test_reset_mid();
        test_back_to_back();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
